// File: rtl/paddle_ctrl_if.sv
// Button-level and paddle-position bundle between the synchronizer side and paddle_ctrl.
interface paddle_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic [9:0] paddle_y;
   logic       up_db;
   logic       down_db;
   logic       at_top;
   logic       at_bottom;

   modport master (
      output btn_up, btn_down,
      input  paddle_y, up_db, down_db, at_top, at_bottom
   );

   modport slave (
      input  btn_up, btn_down,
      output paddle_y, up_db, down_db, at_top, at_bottom
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Debounces up/down buttons and steps a clamped paddle position at a fixed rate while held.
module paddle_ctrl #(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned MOVE_DIV   = 500_000,
   parameter int unsigned STEP       = 1,
   parameter int unsigned SCREEN_H   = 480,
   parameter int unsigned PADDLE_H   = 80,
   parameter int unsigned Y_INIT     = 200
) (
   input logic          clk,
   input logic          rst,
   paddle_ctrl_if.slave pif
);
   localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned MOVE_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int unsigned Y_W    = 10;
   localparam int unsigned YE_W   = 11;

   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [MOVE_W-1:0] MOVE_MAX = MOVE_W'(MOVE_DIV - 1);
   localparam logic [YE_W-1:0]   STEP_E   = YE_W'(STEP);
   localparam logic [YE_W-1:0]   Y_MAX_E  = YE_W'(SCREEN_H - PADDLE_H);
   localparam logic [Y_W-1:0]    Y_MAX    = Y_W'(SCREEN_H - PADDLE_H);
   localparam logic [Y_W-1:0]    Y_RST    = Y_W'(Y_INIT);

   typedef enum logic [1:0] {
      DIR_IDLE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

   // Bit 0 is the up button, bit 1 the down button.
   logic [1:0]        raw_c;
   logic [1:0]        db_q, db_d;
   logic [DEB_W-1:0]  deb_cnt_q [2];
   logic [DEB_W-1:0]  deb_cnt_d [2];
   logic [MOVE_W-1:0] move_cnt_q, move_cnt_d;
   dir_e              last_dir_q, last_dir_d, dir_c;
   logic              step_c;
   logic [YE_W-1:0]   y_ext_c, y_up_c, y_dn_c;
   logic [Y_W-1:0]    paddle_y_q, paddle_y_d;
   logic              at_top_q, at_bottom_q;

   assign raw_c = {pif.btn_down, pif.btn_up};

   // Stable-interval filter: the raw level must differ for DEB_CYCLES edges in a row.
   always_comb begin
      db_d         = db_q;
      deb_cnt_d[0] = '0;
      deb_cnt_d[1] = '0;
      for (int i = 0; i < 2; i++) begin
         if (raw_c[i] != db_q[i]) begin
            if (deb_cnt_q[i] == DEB_MAX) begin
               db_d[i] = raw_c[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_comb begin
      dir_c = DIR_IDLE;
      if (db_q == 2'b01) begin
         dir_c = DIR_UP;
      end else if (db_q == 2'b10) begin
         dir_c = DIR_DOWN;
      end
   end

   // Rate divider restarts on any direction change; steps saturate at the screen limits.
   always_comb begin
      y_ext_c    = {1'b0, paddle_y_q};
      y_up_c     = (y_ext_c < STEP_E) ? '0 : y_ext_c - STEP_E;
      y_dn_c     = ((y_ext_c + STEP_E) > Y_MAX_E) ? Y_MAX_E : y_ext_c + STEP_E;
      last_dir_d = dir_c;
      move_cnt_d = '0;
      step_c     = 1'b0;
      paddle_y_d = paddle_y_q;
      if ((dir_c != DIR_IDLE) && (dir_c == last_dir_q)) begin
         if (move_cnt_q == MOVE_MAX) begin
            step_c = 1'b1;
         end else begin
            move_cnt_d = move_cnt_q + MOVE_W'(1);
         end
      end
      if (step_c) begin
         paddle_y_d = (dir_c == DIR_UP) ? y_up_c[Y_W-1:0] : y_dn_c[Y_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db_q         <= '0;
         deb_cnt_q[0] <= '0;
         deb_cnt_q[1] <= '0;
         move_cnt_q   <= '0;
         last_dir_q   <= DIR_IDLE;
         paddle_y_q   <= Y_RST;
         at_top_q     <= (Y_RST == '0);
         at_bottom_q  <= (Y_RST == Y_MAX);
      end else begin
         db_q         <= db_d;
         deb_cnt_q[0] <= deb_cnt_d[0];
         deb_cnt_q[1] <= deb_cnt_d[1];
         move_cnt_q   <= move_cnt_d;
         last_dir_q   <= last_dir_d;
         paddle_y_q   <= paddle_y_d;
         at_top_q     <= (paddle_y_d == '0);
         at_bottom_q  <= (paddle_y_d == Y_MAX);
      end
   end

   assign pif.paddle_y  = paddle_y_q;
   assign pif.up_db     = db_q[0];
   assign pif.down_db   = db_q[1];
   assign pif.at_top    = at_top_q;
   assign pif.at_bottom = at_bottom_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed plus random stimulus for paddle_ctrl, checked each cycle against an edge-timestamp model.
module tb_paddle_ctrl;
   localparam int DEB   = 4;
   localparam int MDIV  = 3;
   localparam int STEP  = 2;
   localparam int SCR_H = 20;
   localparam int PAD_H = 6;
   localparam int YINIT = 7;
   localparam int YMAX  = SCR_H - PAD_H;

   logic clk;
   logic rst_r;
   logic up_r;
   logic dn_r;
   int   n_cmp;
   int   n_err;

   // Model state: debounced levels, run lengths, direction and the edge where it began.
   int m_y;
   int m_db [2];
   int m_run [2];
   int m_dir;
   int m_e0;
   int m_n;
   int y_snap;
   bit seen;

   paddle_ctrl_if pif ();

   assign pif.btn_up   = up_r;
   assign pif.btn_down = dn_r;

   paddle_ctrl #(
      .DEB_CYCLES (DEB),
      .MOVE_DIV   (MDIV),
      .STEP       (STEP),
      .SCREEN_H   (SCR_H),
      .PADDLE_H   (PAD_H),
      .Y_INIT     (YINIT)
   ) dut (
      .clk (clk),
      .rst (rst_r),
      .pif (pif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int dir_of(input int u, input int d);
      if ((u != 0) && (d == 0)) return 1;
      if ((d != 0) && (u == 0)) return 2;
      return 0;
   endfunction

   task automatic model_edge();
      int raw [2];
      int nd;
      bit stepping;
      m_n++;
      if (rst_r) begin
         m_y = YINIT;
         m_db[0] = 0; m_db[1] = 0;
         m_run[0] = 0; m_run[1] = 0;
         m_dir = 0;
         m_e0  = m_n;
         return;
      end
      stepping = (m_dir != 0) && ((m_n - m_e0) >= MDIV + 1) && (((m_n - m_e0 - 1) % MDIV) == 0);
      if (stepping) begin
         if (m_dir == 1) m_y = (m_y - STEP < 0) ? 0 : m_y - STEP;
         else            m_y = (m_y + STEP > YMAX) ? YMAX : m_y + STEP;
      end
      raw[0] = int'(up_r);
      raw[1] = int'(dn_r);
      for (int i = 0; i < 2; i++) begin
         if (raw[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
               m_db[i]  = raw[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      nd = dir_of(m_db[0], m_db[1]);
      if (nd != m_dir) begin
         m_dir = nd;
         m_e0  = m_n;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_paddle_y",  32'(pif.paddle_y),  32'(m_y));
      chk("model_up_db",     32'(pif.up_db),     32'(m_db[0]));
      chk("model_down_db",   32'(pif.down_db),   32'(m_db[1]));
      chk("model_at_top",    32'(pif.at_top),    32'(m_y == 0));
      chk("model_at_bottom", 32'(pif.at_bottom), 32'(m_y == YMAX));
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      m_y = YINIT; m_db[0] = 0; m_db[1] = 0; m_run[0] = 0; m_run[1] = 0;
      m_dir = 0; m_e0 = 0; m_n = 0;
      rst_r = 1'b1; up_r = 1'b0; dn_r = 1'b0;

      tick(); tick();
      chk("rst_paddle_y",  32'(pif.paddle_y),  32'd7);
      chk("rst_up_db",     32'(pif.up_db),     32'd0);
      chk("rst_down_db",   32'(pif.down_db),   32'd0);
      chk("rst_at_top",    32'(pif.at_top),    32'd0);
      chk("rst_at_bottom", 32'(pif.at_bottom), 32'd0);
      rst_r = 1'b0;

      // Three-cycle glitch must not flip the debounced level.
      up_r = 1'b1;
      repeat (3) tick();
      up_r = 1'b0;
      repeat (3) tick();
      chk("glitch_up_db",    32'(pif.up_db),    32'd0);
      chk("glitch_paddle_y", 32'(pif.paddle_y), 32'd7);

      up_r = 1'b1;
      for (int r = 0; r <= 20; r++) begin
         tick();
         if (r == 2)  chk("deb_r2_up_db", 32'(pif.up_db), 32'd0);
         if (r == 3)  chk("deb_r3_up_db", 32'(pif.up_db), 32'd1);
         if (r == 6)  chk("up_r6",  32'(pif.paddle_y), 32'd7);
         if (r == 7)  chk("up_r7",  32'(pif.paddle_y), 32'd5);
         if (r == 10) chk("up_r10", 32'(pif.paddle_y), 32'd3);
         if (r == 13) chk("up_r13", 32'(pif.paddle_y), 32'd1);
         if (r == 15) chk("up_r15_at_top", 32'(pif.at_top), 32'd0);
         if (r == 16) begin
            chk("up_r16", 32'(pif.paddle_y), 32'd0);
            chk("up_r16_at_top", 32'(pif.at_top), 32'd1);
         end
         if (r == 20) chk("up_r20_clamped", 32'(pif.paddle_y), 32'd0);
      end

      // Reverse straight into a long down run and clamp at the bottom.
      up_r = 1'b0; dn_r = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick();
         if (pif.paddle_y == 10'd12) seen = 1'b1;
      end
      chk("down_reach_12", 32'(pif.paddle_y), 32'd12);
      seen = 1'b0;
      for (int k = 0; k < MDIV + 1 && !seen; k++) begin
         tick();
         if (pif.paddle_y != 10'd12) seen = 1'b1;
      end
      chk("down_first_clamp_14", 32'(pif.paddle_y), 32'd14);
      repeat (7) tick();
      chk("down_hold_14",   32'(pif.paddle_y),  32'd14);
      chk("down_at_bottom", 32'(pif.at_bottom), 32'd1);

      // Move up, then press both so the paddle freezes.
      dn_r = 1'b0; up_r = 1'b1;
      repeat (11) tick();
      dn_r = 1'b1;
      repeat (4) tick();
      chk("both_down_db", 32'(pif.down_db), 32'd1);
      y_snap = m_y;
      repeat (10) tick();
      chk("both_frozen", 32'(pif.paddle_y), 32'(y_snap));

      up_r = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         tick();
         if (pif.up_db == 1'b0) seen = 1'b1;
      end
      chk("release_up_db", 32'(pif.up_db), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k < 4) chk("rev_wait", 32'(pif.paddle_y), 32'(y_snap));
         else       chk("rev_step_4", 32'(pif.paddle_y), 32'(y_snap + STEP));
      end

      // Reset lands one edge before the next scheduled step.
      tick();
      rst_r = 1'b1;
      tick();
      rst_r = 1'b0;
      chk("midrst_paddle_y", 32'(pif.paddle_y), 32'd7);
      tick();
      chk("midrst_no_step",  32'(pif.paddle_y), 32'd7);
      chk("midrst_down_db0", 32'(pif.down_db),  32'd0);
      repeat (2) tick();
      chk("midrst_deb_r2", 32'(pif.down_db), 32'd0);
      tick();
      chk("midrst_deb_r3", 32'(pif.down_db), 32'd1);
      repeat (3) tick();
      chk("midrst_before_step", 32'(pif.paddle_y), 32'd7);
      tick();
      chk("midrst_first_step", 32'(pif.paddle_y), 32'd9);

      // Random button levels with occasional resets.
      for (int s = 0; s < 80; s++) begin
         up_r  = 1'($urandom_range(0, 1));
         dn_r  = 1'($urandom_range(0, 1));
         rst_r = ($urandom_range(0, 39) == 0);
         tick();
         rst_r = 1'b0;
         repeat ($urandom_range(0, 14)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
